// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared FSM encoding, slave address map, psel encodings and the
// address decoder used by apb_req_arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam logic [31:0] SLV0_BASE  = 32'h8000_0000;
    localparam logic [31:0] SLV0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] SLV1_BASE  = 32'h8400_0000;
    localparam logic [31:0] SLV1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] SLV2_BASE  = 32'h8800_0000;
    localparam logic [31:0] SLV2_LIMIT = 32'h8BFF_FFFF;

    localparam logic [2:0] PSEL_NONE = 3'b000;
    localparam logic [2:0] PSEL_S0   = 3'b001;
    localparam logic [2:0] PSEL_S1   = 3'b010;
    localparam logic [2:0] PSEL_S2   = 3'b100;

    localparam int TIMEOUT_CYCLES_DEF = 16;

    // Address to one-hot slave select; PSEL_NONE flags a decode miss.
    function automatic logic [2:0] decode_psel(input logic [31:0] addr);
        logic [2:0] sel;
        if ((addr >= SLV0_BASE) && (addr <= SLV0_LIMIT)) begin
            sel = PSEL_S0;
        end else if ((addr >= SLV1_BASE) && (addr <= SLV1_LIMIT)) begin
            sel = PSEL_S1;
        end else if ((addr >= SLV2_BASE) && (addr <= SLV2_LIMIT)) begin
            sel = PSEL_S2;
        end else begin
            sel = PSEL_NONE;
        end
        return sel;
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// apb_rr_pick: combinational round-robin picker; searches upward from
// last_gnt+1 with wrap and returns the first requester found.
module apb_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_idx
);

    logic [IDX_W-1:0] cand_idx_s;
    logic             hit_s;
    logic             found_s;

    // Walk every position exactly once, the previous owner coming last.
    always_comb begin
        winner     = {NUM_REQ{1'b0}};
        winner_idx = {IDX_W{1'b0}};
        found_s    = 1'b0;
        hit_s      = 1'b0;
        cand_idx_s = {IDX_W{1'b0}};
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_idx_s         = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            hit_s              = ~found_s & req[cand_idx_s];
            winner[cand_idx_s] = hit_s;
            winner_idx         = hit_s ? cand_idx_s : winner_idx;
            found_s            = found_s | hit_s;
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master port between NUM_REQ requesters.
// Build macro APB_TIMEOUT_EN adds an ACCESS wait-state timeout (TIMEOUT_CYCLES).
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    done,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [2:0]            psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           paddr,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_e               state_r,     state_s;
    logic [IDX_W-1:0]     last_gnt_r,  last_gnt_s;
    logic [NUM_REQ-1:0]   gnt_r,       gnt_s;
    logic [NUM_REQ-1:0]   done_r,      done_s;
    logic [31:0]          rsp_rdata_r, rsp_rdata_s;
    logic                 rsp_err_r,   rsp_err_s;
    logic [2:0]           psel_r,      psel_s;
    logic                 penable_r,   penable_s;
    logic                 pwrite_r,    pwrite_s;
    logic [31:0]          paddr_r,     paddr_s;
    logic [31:0]          pwdata_r,    pwdata_s;

    logic [NUM_REQ-1:0]   winner_s;
    logic [IDX_W-1:0]     winner_idx_s;
    logic [31:0]          sel_addr_s;
    logic [31:0]          sel_wdata_s;
    logic                 sel_write_s;
    logic [2:0]           dec_psel_s;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req        (req),
        .last_gnt   (last_gnt_r),
        .winner     (winner_s),
        .winner_idx (winner_idx_s)
    );

    // One-hot mux of the winning requester's transfer fields.
    always_comb begin
        sel_addr_s  = 32'h0;
        sel_wdata_s = 32'h0;
        sel_write_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_addr_s  = sel_addr_s  | (req_addr[32*i +: 32]  & {32{winner_s[i]}});
            sel_wdata_s = sel_wdata_s | (req_wdata[32*i +: 32] & {32{winner_s[i]}});
            sel_write_s = sel_write_s | (req_write[i] & winner_s[i]);
        end
        dec_psel_s = decode_psel(sel_addr_s);
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             tmo_expire_s;

    // Counts consecutive not-ready ACCESS cycles; the last one expires the transfer.
    always_comb begin
        tmo_expire_s = (state_r == ST_ACCESS) && !pready &&
                       (tmo_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
        if ((state_r == ST_ACCESS) && !pready && !tmo_expire_s) begin
            tmo_cnt_s = tmo_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_s = {CNT_W{1'b0}};
        end
    end

    // Timeout counter register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
`endif

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        state_s     = state_r;
        last_gnt_s  = last_gnt_r;
        gnt_s       = gnt_r;
        done_s      = done_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        psel_s      = psel_r;
        penable_s   = penable_r;
        pwrite_s    = pwrite_r;
        paddr_s     = paddr_r;
        pwdata_s    = pwdata_r;
        case (state_r)
            ST_IDLE: begin
                if (|req) begin
                    paddr_s    = sel_addr_s;
                    pwdata_s   = sel_wdata_s;
                    pwrite_s   = sel_write_s;
                    gnt_s      = winner_s;
                    last_gnt_s = winner_idx_s;
                    penable_s  = 1'b0;
                    psel_s     = dec_psel_s;
                    if (dec_psel_s != PSEL_NONE) begin
                        state_s = ST_SETUP;
                    end else begin
                        // Decode miss: answer immediately without touching the bus.
                        rsp_err_s   = 1'b1;
                        rsp_rdata_s = 32'h0;
                        done_s      = winner_s;
                        state_s     = ST_RESP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                penable_s = 1'b1;
                state_s   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_s      = PSEL_NONE;
                    penable_s   = 1'b0;
                    rsp_rdata_s = pwrite_r ? 32'h0 : prdata;
                    rsp_err_s   = pslverr;
                    done_s      = gnt_r;
                    state_s     = ST_RESP;
                end
`ifdef APB_TIMEOUT_EN
                else if (tmo_expire_s) begin
                    psel_s      = PSEL_NONE;
                    penable_s   = 1'b0;
                    rsp_rdata_s = 32'h0;
                    rsp_err_s   = 1'b1;
                    done_s      = gnt_r;
                    state_s     = ST_RESP;
                end
`endif
                else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                gnt_s     = {NUM_REQ{1'b0}};
                done_s    = {NUM_REQ{1'b0}};
                rsp_err_s = 1'b0;
                state_s   = ST_IDLE;
            end
            default: begin
                gnt_s     = {NUM_REQ{1'b0}};
                done_s    = {NUM_REQ{1'b0}};
                rsp_err_s = 1'b0;
                psel_s    = PSEL_NONE;
                penable_s = 1'b0;
                state_s   = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with top priority.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_r     <= ST_IDLE;
            last_gnt_r  <= IDX_W'(NUM_REQ - 1);
            gnt_r       <= {NUM_REQ{1'b0}};
            done_r      <= {NUM_REQ{1'b0}};
            rsp_rdata_r <= 32'h0;
            rsp_err_r   <= 1'b0;
            psel_r      <= PSEL_NONE;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= 32'h0;
            pwdata_r    <= 32'h0;
        end else begin
            state_r     <= state_s;
            last_gnt_r  <= last_gnt_s;
            gnt_r       <= gnt_s;
            done_r      <= done_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
            psel_r      <= psel_s;
            penable_r   <= penable_s;
            pwrite_r    <= pwrite_s;
            paddr_r     <= paddr_s;
            pwdata_r    <= pwdata_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;
    assign psel      = psel_r;
    assign penable   = penable_r;
    assign pwrite    = pwrite_r;
    assign paddr     = paddr_r;
    assign pwdata    = pwdata_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed stimulus with a response scoreboard for apb_req_arbiter.
module tb_apb_req_arbiter;

    localparam int N = 3;

    typedef struct packed {
        logic [N-1:0] done;
        logic [31:0]  rdata;
        logic         err;
    } exp_t;

    logic            hclk = 1'b0;
    logic            hresetn;
    logic [N-1:0]    req, req_write;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]    gnt, done;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [2:0]      psel;
    logic            penable, pwrite;
    logic [31:0]     paddr, pwdata, prdata;
    logic            pready, pslverr;

    int          slv_ws = 0;
    logic        slv_stuck = 1'b0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err = 1'b0;
    int          acc_cnt = 0;
    int          cyc = 0;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [N-1:0] prev_done = '0;

    apb_req_arbiter #(.NUM_REQ(N)) dut (
        .hclk(hclk), .hresetn(hresetn), .req(req), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 hclk = ~hclk;

    always @(posedge hclk) cyc <= cyc + 1;

    // Slave model: slv_ws not-ready ACCESS cycles, then ready (unless stuck).
    always @(posedge hclk) begin
        if ((|psel) && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end
    assign pready  = (|psel) && penable && !slv_stuck && (acc_cnt >= slv_ws);
    assign prdata  = slv_rdata;
    assign pslverr = slv_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic push(input logic [N-1:0] d, input logic [31:0] rd, input logic e);
        exp_t x;
        x.done = d; x.rdata = rd; x.err = e;
        exp_q.push_back(x);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_rdata"}, rsp_rdata, 32'h0);
        check({tag, "_err"}, 32'(rsp_err), 32'h0);
        check({tag, "_psel"}, 32'(psel), 32'h0);
        check({tag, "_penable"}, 32'(penable), 32'h0);
        check({tag, "_pwrite"}, 32'(pwrite), 32'h0);
        check({tag, "_paddr"}, paddr, 32'h0);
        check({tag, "_pwdata"}, pwdata, 32'h0);
    endtask

    task automatic apply_reset();
        hresetn = 1'b0;
        req = '0;
        slv_stuck = 1'b0;
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
    endtask

    // Monitor: pops one expectation per done pulse and checks single-cycle width.
    initial begin
        exp_t e;
        forever begin
            @(negedge hclk);
            if (done != '0) begin
                check("done_single_cycle", 32'(prev_done), 32'h0);
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", 32'(done), 32'(e.done));
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", 32'(rsp_err), 32'(e.err));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sel_cnt, got, last_c;
        bit seen;
        hresetn = 1'b0;
        req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        @(negedge hclk);
        check_all_zero("reset");
        @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);

        // Single read to slave 1, no wait states.
        req_addr[31:0] = 32'h8400_0010; req_write[0] = 1'b0;
        slv_ws = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
        push(3'b001, 32'hDEAD_BEEF, 1'b0);
        req[0] = 1'b1;
        @(negedge hclk);
        check("rd_setup_psel", 32'(psel), 32'h2);
        check("rd_setup_penable", 32'(penable), 32'h0);
        check("rd_setup_gnt", 32'(gnt), 32'h1);
        check("rd_setup_paddr", paddr, 32'h8400_0010);
        @(negedge hclk);
        check("rd_access_psel", 32'(psel), 32'h2);
        check("rd_access_penable", 32'(penable), 32'h1);
        @(negedge hclk);
        check("rd_done_latency", 32'(done), 32'h1);
        check("rd_psel_released", 32'(psel), 32'h0);
        req[0] = 1'b0;
        @(negedge hclk);
        check("rd_done_cleared", 32'(done), 32'h0);
        check("rd_rdata_held", rsp_rdata, 32'hDEAD_BEEF);
        @(negedge hclk);

        // Decode miss from requester 2.
        req_addr[95:64] = 32'h9000_0000; req_write[2] = 1'b0;
        push(3'b100, 32'h0, 1'b1);
        req[2] = 1'b1;
        @(negedge hclk);
        check("miss_done_next", 32'(done), 32'h4);
        check("miss_psel0", 32'(psel), 32'h0);
        req[2] = 1'b0;
        @(negedge hclk);
        check("miss_psel1", 32'(psel), 32'h0);
        @(negedge hclk);

        // All three requesting writes continuously: order 0,1,2,0, 4 cycles apart.
        apply_reset();
        for (int i = 0; i < N; i++) begin
            req_addr[32*i +: 32] = 32'h8000_0000;
            req_wdata[32*i +: 32] = 32'h1000_0000 + 32'(i);
        end
        req_write = '1; slv_rdata = 32'h1234_5678; slv_ws = 0; slv_err = 1'b0;
        push(3'b001, 32'h0, 1'b0); push(3'b010, 32'h0, 1'b0);
        push(3'b100, 32'h0, 1'b0); push(3'b001, 32'h0, 1'b0);
        req = 3'b111;
        got = 0; last_c = 0;
        for (int t = 0; t < 30 && got < 4; t++) begin
            @(negedge hclk);
            if (done != '0) begin
                if (got > 0) check("rr_spacing", 32'(cyc - last_c), 32'd4);
                last_c = cyc;
                got++;
            end
        end
        check("rr_transfer_count", 32'(got), 32'd4);
        req = '0;
        @(negedge hclk);

        // Write to slave 2 with 5 wait states and a slave error.
        req_addr[63:32] = 32'h8800_0004; req_wdata[63:32] = 32'hA5A5_0F0F; req_write[1] = 1'b1;
        slv_ws = 5; slv_err = 1'b1;
        push(3'b010, 32'h0, 1'b1);
        req[1] = 1'b1;
        sel_cnt = 0; seen = 1'b0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge hclk);
            if (t == 0) begin
                req_addr[63:32] = 32'h8000_0000;
                req_wdata[63:32] = 32'h0;
            end
            if (|psel) begin
                sel_cnt++;
                check("ws_psel", 32'(psel), 32'h4);
                check("ws_paddr", paddr, 32'h8800_0004);
                check("ws_pwdata", pwdata, 32'hA5A5_0F0F);
                check("ws_pwrite", 32'(pwrite), 32'h1);
            end
            seen = done[1];
        end
        check("ws_done_seen", 32'(seen), 32'h1);
        check("ws_psel_cycles", 32'(sel_cnt), 32'd7);
        req[1] = 1'b0; slv_ws = 0; slv_err = 1'b0;
        @(negedge hclk);

        // Asynchronous reset in ACCESS, then requester 0 must win first again.
        req_addr[31:0] = 32'h8000_0000; req_write[0] = 1'b0;
        slv_stuck = 1'b1;
        req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge hclk);
            seen = penable;
        end
        check("pre_reset_access", 32'(seen), 32'h1);
        #2 hresetn = 1'b0;
        #1 check_all_zero("async_reset");
        req = '0; slv_stuck = 1'b0;
        @(negedge hclk);
        req_addr[31:0] = 32'h8000_0100; req_addr[63:32] = 32'h8400_0200;
        req_write = '0; slv_rdata = 32'hCAFE_0001;
        push(3'b001, 32'hCAFE_0001, 1'b0);
        push(3'b010, 32'hCAFE_0001, 1'b0);
        req = 3'b011;
        hresetn = 1'b1;
        got = 0;
        for (int t = 0; t < 20 && got < 2; t++) begin
            @(negedge hclk);
            if (done != '0) begin
                got++;
                req = req & ~done;
            end
        end
        check("post_reset_count", 32'(got), 32'd2);
        req = '0;
        @(negedge hclk);

        // Slave never ready.
        req_addr[95:64] = 32'h8400_0000; req_write[2] = 1'b0;
        slv_stuck = 1'b1;
`ifdef APB_TIMEOUT_EN
        push(3'b100, 32'h0, 1'b1);
        req[2] = 1'b1;
        sel_cnt = 0; seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
            @(negedge hclk);
            if (|psel) sel_cnt++;
            seen = done[2];
        end
        check("tmo_done_seen", 32'(seen), 32'h1);
        check("tmo_psel_cycles", 32'(sel_cnt), 32'd17);
        req[2] = 1'b0;
        slv_stuck = 1'b0;
        @(negedge hclk);
`else
        req[2] = 1'b1;
        repeat (40) @(negedge hclk);
        check("stuck_psel", 32'(psel), 32'h2);
        check("stuck_penable", 32'(penable), 32'h1);
        check("stuck_no_done", 32'(done), 32'h0);
        apply_reset();
`endif

        repeat (3) @(negedge hclk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
